// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register file write arbiter with optional x1..x31 clear (macro RF_CLEAR_EN)
module regfile_write_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        WriteEnable3,
    output logic [4:0]  Address3,
    output logic [31:0] WD3
);

    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    // 1 when B was the most recent accepted requester; resets to 1 so A wins the first tie
    logic        last_b_q, last_b_d;
    logic        arb_en;
    logic        grant_a, grant_b;

`ifdef RF_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    assign arb_en     = (state_q == ST_IDLE);
    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = done_q;
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign arb_en             = 1'b1;
    assign clear_busy         = 1'b0;
    assign clear_done         = 1'b0;
`endif

    // Grant selection: single requester wins outright, ties by round-robin or fixed A priority
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst && arb_en) begin
            if (a_valid && b_valid) begin
                if (ROUND_ROBIN != 0) begin
                    grant_a = last_b_q;
                    grant_b = !last_b_q;
                end else begin
                    grant_a = 1'b1;
                end
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Next write-port value, last-grant update and clear sequencing
    always_comb begin
        we_d     = 1'b0;
        addr_d   = addr_q;
        wd_d     = wd_q;
        last_b_d = last_b_q;
        if (grant_a) begin
            we_d     = (a_addr != 5'd0);
            addr_d   = a_addr;
            wd_d     = a_data;
            last_b_d = 1'b0;
        end else if (grant_b) begin
            we_d     = (b_addr != 5'd0);
            addr_d   = b_addr;
            wd_d     = b_data;
            last_b_d = 1'b1;
        end
`ifdef RF_CLEAR_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // clear_start is not looked at here, so a repeat pulse cannot restart or extend
                we_d   = 1'b1;
                addr_d = cnt_q;
                wd_d   = 32'd0;
                if (cnt_q == 5'd31) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`endif
    end

    // Registered write port and grant history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            wd_q     <= 32'd0;
            last_b_q <= 1'b1;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            last_b_q <= last_b_d;
        end
    end

`ifdef RF_CLEAR_EN
    // Clear FSM state, address counter and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
`endif

    assign WriteEnable3 = we_q;
    assign Address3     = addr_q;
    assign WD3          = wd_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, b_valid, clear_start;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, clear_busy, clear_done, we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        f_a_ready, f_b_ready, f_busy, f_done, f_we;
    logic [4:0]  f_addr;
    logic [31:0] f_wd;

    regfile_write_arbiter #(.ROUND_ROBIN(1)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .WriteEnable3(we), .Address3(addr), .WD3(wd)
    );

    regfile_write_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(f_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(f_b_ready),
        .clear_start(clear_start), .clear_busy(f_busy), .clear_done(f_done),
        .WriteEnable3(f_we), .Address3(f_addr), .WD3(f_wd)
    );

    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk) if (we) rf[addr] <= wd;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
    } wr_t;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ea, eb, fa, fb;
    } vec_t;

    wr_t         sb_q[$];
    vec_t        vecs[14];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  exp_addr;
    logic [31:0] exp_wd;
    logic        done_seen;
    int          done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic ea, input logic eb, input logic fa, input logic fb);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ea = ea; v.eb = eb; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic push_exp(input logic w, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.we = w; e.addr = a; e.wd = d;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input int idx);
        wr_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty%0d: got empty queue expected entry", idx);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("out%0d we", idx), we, e.we);
            chk($sformatf("out%0d addr", idx), addr, e.addr);
            chk($sformatf("out%0d wd", idx), wd, e.wd);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_start = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2;
        #12;
        chk("rst we", we, 1'b0);
        chk("rst addr", addr, 5'd0);
        chk("rst wd", wd, 32'd0);
        chk("rst a_ready", a_ready, 1'b0);
        chk("rst b_ready", b_ready, 1'b0);
        chk("rst busy", clear_busy, 1'b0);
        chk("rst done", clear_done, 1'b0);
        chk("rst fp a_ready", f_a_ready, 1'b0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        //               A valid/addr/data        B valid/addr/data         rr_a rr_b fp_a fp_b
        vecs[0]  = mk(1, 5'd5,  32'hAAAAAAAA, 0, 5'd0,  32'h0,        1, 0, 1, 0);
        vecs[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0);
        vecs[2]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFFFFFF, 0, 1, 0, 1);
        vecs[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0);
        vecs[4]  = mk(1, 5'd10, 32'hBBBBBBBB, 1, 5'd11, 32'hCCCCCCCC, 1, 0, 1, 0);
        vecs[5]  = mk(1, 5'd10, 32'hBBBBBBBB, 1, 5'd11, 32'hCCCCCCCC, 0, 1, 1, 0);
        vecs[6]  = mk(1, 5'd10, 32'hBBBBBBBB, 1, 5'd11, 32'hCCCCCCCC, 1, 0, 1, 0);
        vecs[7]  = mk(1, 5'd10, 32'hBBBBBBBB, 1, 5'd11, 32'hCCCCCCCC, 0, 1, 1, 0);
        vecs[8]  = mk(1, 5'd31, 32'h12345678, 0, 5'd0,  32'h0,        1, 0, 1, 0);
        vecs[9]  = mk(1, 5'd3,  32'h33333333, 1, 5'd4,  32'h44444444, 0, 1, 1, 0);
        vecs[10] = mk(0, 5'd0,  32'h0,        1, 5'd6,  32'h66666666, 0, 1, 0, 1);
        vecs[11] = mk(1, 5'd8,  32'h88888888, 1, 5'd9,  32'h99999999, 1, 0, 1, 0);
        vecs[12] = mk(1, 5'd0,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 1, 0);
        vecs[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0);

        exp_addr = 5'd0;
        exp_wd   = 32'd0;
        push_exp(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            @(negedge clk);
            chk($sformatf("v%0d a_ready", i), a_ready, vecs[i].ea);
            chk($sformatf("v%0d b_ready", i), b_ready, vecs[i].eb);
            chk($sformatf("v%0d fp a_ready", i), f_a_ready, vecs[i].fa);
            chk($sformatf("v%0d fp b_ready", i), f_b_ready, vecs[i].fb);
            check_out(i);
            if (vecs[i].ea) begin
                exp_addr = vecs[i].aa; exp_wd = vecs[i].ad;
                push_exp(vecs[i].aa != 5'd0, exp_addr, exp_wd);
            end else if (vecs[i].eb) begin
                exp_addr = vecs[i].ba; exp_wd = vecs[i].bd;
                push_exp(vecs[i].ba != 5'd0, exp_addr, exp_wd);
            end else begin
                push_exp(1'b0, exp_addr, exp_wd);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check_out(14);
        @(posedge clk);
        #1;
        chk("rf x5", rf[5], 32'hAAAAAAAA);
        chk("rf x0", rf[0], 32'h0);
        chk("rf x11", rf[11], 32'hCCCCCCCC);
        chk("rf x31", rf[31], 32'h12345678);

        // Async reset lands while a write is on the port; last-grant returns to B
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h0C0C0C0C;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("pre-rst we", we, 1'b1);
        #3;
        a_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk("async rst we", we, 1'b0);
        chk("async rst addr", addr, 5'd0);
        chk("async rst wd", wd, 32'd0);
        chk("async rst a_ready", a_ready, 1'b0);
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b1; a_addr = 5'd20; a_data = 32'h20202020;
        b_valid = 1'b1; b_addr = 5'd21; b_data = 32'h21212121;
        @(negedge clk);
        chk("post-rst tie a_ready", a_ready, 1'b1);
        chk("post-rst tie b_ready", b_ready, 1'b0);
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("post-rst addr", addr, 5'd20);

`ifdef RF_CLEAR_EN
        // Clear with a same-cycle handshake, a held requester and an ignored second pulse
        @(posedge clk);
        #1;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hAAAAAAAA; clear_start = 1'b1;
        @(negedge clk);
        chk("clr0 a_ready", a_ready, 1'b1);
        chk("clr0 busy", clear_busy, 1'b0);
        @(posedge clk);
        #1;
        clear_start = 1'b0; a_addr = 5'd7; a_data = 32'h77777777;
        @(negedge clk);
        chk("clr1 a_ready", a_ready, 1'b0);
        chk("clr1 busy", clear_busy, 1'b1);
        chk("clr1 we", we, 1'b1);
        chk("clr1 addr", addr, 5'd5);
        chk("clr1 wd", wd, 32'hAAAAAAAA);
        done_cnt = 0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            clear_start = (k == 5);
            @(negedge clk);
            chk($sformatf("clr k%0d we", k), we, 1'b1);
            chk($sformatf("clr k%0d addr", k), addr, k[4:0]);
            chk($sformatf("clr k%0d wd", k), wd, 32'd0);
            chk($sformatf("clr k%0d busy", k), clear_busy, k < 31);
            chk($sformatf("clr k%0d a_ready", k), a_ready, k == 31);
            if (clear_done) done_cnt++;
        end
        chk("clr done at end", clear_done, 1'b1);
        @(posedge clk);
        #1;
        a_valid = 1'b0; clear_start = 1'b0;
        @(negedge clk);
        if (clear_done) done_cnt++;
        chk("clr done pulses", done_cnt, 1);
        chk("clr busy after", clear_busy, 1'b0);
        chk("clr resume addr", addr, 5'd7);
        chk("clr resume wd", wd, 32'h77777777);
        @(posedge clk);
        #1;
        chk("clr rf x5", rf[5], 32'h0);
        chk("clr rf x31", rf[31], 32'h0);
        chk("clr rf x7", rf[7], 32'h77777777);

        // Reset in the middle of a clear aborts it without a done pulse
        a_valid = 1'b1; a_addr = 5'd31; a_data = 32'h12345678;
        @(posedge clk);
        #1;
        a_valid = 1'b0; clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort busy before", clear_busy, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("abort we", we, 1'b0);
        chk("abort addr", addr, 5'd0);
        chk("abort wd", wd, 32'd0);
        chk("abort busy", clear_busy, 1'b0);
        chk("abort done", clear_done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (clear_done || clear_busy) done_seen = 1'b1;
        end
        chk("abort no restart", done_seen, 1'b0);
        chk("abort rf x31", rf[31], 32'h12345678);
`else
        // Without the clear feature clear_start must not disturb arbitration
        @(posedge clk);
        #1;
        a_valid = 1'b1; a_addr = 5'd13; a_data = 32'h13131313; clear_start = 1'b1;
        @(negedge clk);
        chk("noclr a_ready0", a_ready, 1'b1);
        chk("noclr busy0", clear_busy, 1'b0);
        @(posedge clk);
        #1;
        clear_start = 1'b0; a_addr = 5'd14; a_data = 32'h14141414;
        @(negedge clk);
        chk("noclr busy1", clear_busy, 1'b0);
        chk("noclr a_ready1", a_ready, 1'b1);
        chk("noclr we1", we, 1'b1);
        chk("noclr addr1", addr, 5'd13);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("noclr done", clear_done, 1'b0);
        chk("noclr addr2", addr, 5'd14);
        chk("noclr wd2", wd, 32'h14141414);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
- REQ-001 Parameter ROUND_ROBIN, default 1: 1 = round-robin between requesters, 0 = fixed priority (A wins).
- REQ-002 clk  input  1  single clock; all state updates on posedge.
- REQ-003 rst  input  1  asynchronous, active-low reset.
- REQ-004 a_valid / a_addr / a_data  input  1/5/32  requester A (core writeback) write request.
- REQ-005 a_ready  output  1  A request accepted this cycle when a_valid && a_ready.
- REQ-006 b_valid / b_addr / b_data  input  1/5/32  requester B (debug/loader) write request.
- REQ-007 b_ready  output  1  B request accepted this cycle when b_valid && b_ready.
- REQ-008 clear_start  input  1  pulse: request zeroing of x1..x31.
- REQ-009 clear_busy / clear_done  output  1/1  clear in progress / one-cycle completion pulse.
- REQ-010 WriteEnable3 / Address3 / WD3  output  1/5/32  registered write port to Register_File.

Function
- REQ-011 FSM states: IDLE, CLEAR; in IDLE the block SHALL arbitrate A and B every cycle.
- REQ-012 a_ready, b_ready SHALL be combinational from current valids and grant state; at most one SHALL be 1 per cycle.
- REQ-013 Only one valid: that requester SHALL get ready=1 in IDLE.
- REQ-014 Both valid, ROUND_ROBIN=1: grant the requester not granted last; ROUND_ROBIN=0: grant A.
- REQ-015 last-grant register SHALL update only on an accepted transfer.
- REQ-016 Accepted write SHALL appear on WriteEnable3=1, Address3, WD3 exactly one cycle after the handshake cycle (latency 1).
- REQ-017 Cycle with no accepted transfer (and not clearing) SHALL drive WriteEnable3=0 next cycle; Address3/WD3 hold.
- REQ-018 Accepted write to address 0 SHALL complete the handshake but drive WriteEnable3=0 (x0 immutable).
- REQ-019 clear_start in IDLE SHALL enter CLEAR next cycle; a same-cycle handshake SHALL still be accepted and issued before clear writes.
- REQ-020 In CLEAR: a_ready=b_ready=0, clear_busy=1, one write per cycle WriteEnable3=1, WD3=0, Address3=1,2,...,31 (31 cycles).
- REQ-021 After Address3=31 write, FSM SHALL return to IDLE, clear_busy=0, clear_done=1 for exactly one cycle.
- REQ-022 clear_start while in CLEAR SHALL be ignored (no restart, no extension).
- REQ-023 Pending valids during CLEAR SHALL be held by requesters; first grant resumes in the first IDLE cycle.

Reset
- REQ-024 rst=0 SHALL asynchronously force: FSM=IDLE, WriteEnable3=0, Address3=0, WD3=0, clear_busy=0, clear_done=0, clear counter=1, last-grant=B (A wins first tie).
- REQ-025 rst asserted mid-CLEAR SHALL abort the sequence; no clear_done pulse; remaining registers untouched.
- REQ-026 While rst=0, a_ready=b_ready=0.

Configuration
- REQ-027 Macro RF_CLEAR_EN defined: CLEAR state, counter and clear_done logic SHALL be compiled in per REQ-019..REQ-023.
- REQ-028 RF_CLEAR_EN undefined: clear_start SHALL be ignored, clear_busy and clear_done tied 0, FSM reduced to IDLE only; arbitration unchanged.

Verification
- REQ-029 After reset release, a_valid=1 a_addr=5 a_data=AAAAAAAA -> a_ready=1; next cycle WriteEnable3=1 Address3=5 WD3=AAAAAAAA; RF read of x5 returns AAAAAAAA.
- REQ-030 ROUND_ROBIN=1, A and B valid for 4 cycles (A: x10/BBBBBBBB, B: x11/CCCCCCCC) -> grants A,B,A,B; Address3 sequence 10,11,10,11.
- REQ-031 ROUND_ROBIN=0, both valid 3 cycles -> a_ready=1 each cycle, b_ready=0 throughout.
- REQ-032 b_valid=1 b_addr=0 b_data=FFFFFFFF -> b_ready=1, next cycle WriteEnable3=0; x0 reads 00000000.
- REQ-033 RF_CLEAR_EN: preload x5=AAAAAAAA, x31=12345678; pulse clear_start -> clear_busy=1 for 31 cycles, Address3 1..31 with WD3=0, clear_done pulse once; x5=x31=00000000; a_valid held during clear gets a_ready only after clear_busy falls.
- REQ-034 RF_CLEAR_EN: rst=0 at clear cycle 10 -> outputs zero immediately, no clear_done, x31 retains 12345678 after rst=1.
